nios_dbg_cmd_queue: RTL and testbench

Parametrised successor to the Nios II debug-module system-clock side. It samples the update-DR/update-IR strobes and captured shift register arriving from the TCK domain and synchronises them into `clk`. Each completed DR scan is queued as a command in a small FIFO, and one-cycle take-action / take-no-action pulses are generated per instruction code. It sits between the virtual-JTAG TCK-side shifter and the OCI debug logic (ocimem, break, trace), and adds depth, width and instruction-count generality plus overflow accounting.

---
 rtl/nios_dbg_cmd_queue.sv | 127 ++++++++++++
 tb/tb_nios_dbg_cmd_queue.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios_dbg_cmd_queue.sv
// System-clock side of the Nios II debug module: synchronises the TCK-domain
// update strobes, queues completed DR scans and decodes them into action pulses.
module nios_dbg_cmd_queue #(
  parameter int SR_WIDTH    = 38,
  parameter int IR_WIDTH    = 2,
  parameter int ACT_BIT     = 34,
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       vs_udr,
  input  logic                       vs_uir,
  input  logic                       jtag_rti,
  input  logic [IR_WIDTH-1:0]        ir_in,
  input  logic [SR_WIDTH-1:0]        sr,
  input  logic                       cmd_ready,
  input  logic                       ovf_clear,
  output logic                       cmd_valid,
  output logic [IR_WIDTH-1:0]        cmd_ir,
  output logic [SR_WIDTH-1:0]        cmd_data,
  output logic [SR_WIDTH-1:0]        jdo,
  output logic [(2**IR_WIDTH)-1:0]   take_action,
  output logic [(2**IR_WIDTH)-1:0]   take_no_action,
  output logic                       ir_update,
  output logic                       st_ready_test_idle,
  output logic                       ovf,
  output logic [7:0]                 drop_count
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int ACT_N = 2 ** IR_WIDTH;
  localparam int ENT_W = IR_WIDTH + SR_WIDTH;
  localparam logic [PTR_W:0]   PTR_ONE  = 1;
  localparam logic [ACT_N-1:0] ONEHOT_0 = 1;

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  logic [SYNC_STAGES-1:0] udr_sync, uir_sync, rti_sync, vld_sync;
  logic                   udr_dly, uir_dly, udr_armed, uir_armed;
  logic                   udr_rise, uir_rise;

  // Stage: synchronisers. vld_sync marks when the chains hold only post-reset
  // samples; a strobe is armed once it has been seen low, so a level that is
  // already high at reset release never counts as a rising edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      udr_sync  <= '0;
      uir_sync  <= '0;
      rti_sync  <= '0;
      vld_sync  <= '0;
      udr_dly   <= 1'b0;
      uir_dly   <= 1'b0;
      udr_armed <= 1'b0;
      uir_armed <= 1'b0;
    end else begin
      udr_sync  <= {udr_sync[SYNC_STAGES-2:0], vs_udr};
      uir_sync  <= {uir_sync[SYNC_STAGES-2:0], vs_uir};
      rti_sync  <= {rti_sync[SYNC_STAGES-2:0], jtag_rti};
      vld_sync  <= {vld_sync[SYNC_STAGES-2:0], 1'b1};
      udr_dly   <= udr_sync[SYNC_STAGES-1];
      uir_dly   <= uir_sync[SYNC_STAGES-1];
      udr_armed <= udr_armed | (vld_sync[SYNC_STAGES-1] & ~udr_sync[SYNC_STAGES-1]);
      uir_armed <= uir_armed | (vld_sync[SYNC_STAGES-1] & ~uir_sync[SYNC_STAGES-1]);
    end
  end

  assign udr_rise           = udr_sync[SYNC_STAGES-1] & ~udr_dly & udr_armed;
  assign uir_rise           = uir_sync[SYNC_STAGES-1] & ~uir_dly & uir_armed;
  assign st_ready_test_idle = rti_sync[SYNC_STAGES-1];

  logic [PTR_W:0]   wr_ptr, rd_ptr;
  logic [ENT_W-1:0] mem [FIFO_DEPTH];
  logic [ENT_W-1:0] head;
  logic             empty, full, pop, push, drop;
  logic [ACT_N-1:0] ir_onehot;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                     (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
  assign pop       = ~empty & cmd_ready;
  assign push      = udr_rise & (~full | pop);
  assign drop      = udr_rise & full & ~pop;
  assign head      = mem[rd_ptr[PTR_W-1:0]];
  assign cmd_valid = ~empty;
  assign cmd_ir    = head[ENT_W-1 -: IR_WIDTH];
  assign cmd_data  = head[SR_WIDTH-1:0];
  assign ir_onehot = ONEHOT_0 << cmd_ir;

  // Stage: command storage (data only, discarded logically by pointer reset)
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[PTR_W-1:0]] <= {ir_in, sr};
  end

  // Stage: queue control, pop decode and overflow accounting
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      jdo            <= '0;
      take_action    <= '0;
      take_no_action <= '0;
      ir_update      <= 1'b0;
      ovf            <= 1'b0;
      drop_count     <= 8'd0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_ONE;
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_ONE;
        jdo    <= cmd_data;
      end
      take_action    <= (pop &  cmd_data[ACT_BIT]) ? ir_onehot : '0;
      take_no_action <= (pop & ~cmd_data[ACT_BIT]) ? ir_onehot : '0;
      ir_update      <= uir_rise;
      if (drop) begin
        ovf        <= 1'b1;
        drop_count <= ovf_clear ? 8'd1 : sat_inc(drop_count);
      end else if (ovf_clear) begin
        ovf        <= 1'b0;
        drop_count <= 8'd0;
      end
    end
  end

endmodule

// File: tb/tb_nios_dbg_cmd_queue.sv
// Bench for nios_dbg_cmd_queue: table vectors, hand-written corner sequences
// and random scan/pop/clear traffic against a transaction-level queue model.
module tb_nios_dbg_cmd_queue;

  logic        clk = 1'b0;
  logic        reset, vs_udr, vs_uir, jtag_rti, cmd_ready, ovf_clear;
  logic [1:0]  ir_in;
  logic [37:0] sr;
  logic        cmd_valid, ir_update, st_ready_test_idle, ovf;
  logic [1:0]  cmd_ir;
  logic [37:0] cmd_data, jdo;
  logic [3:0]  take_action, take_no_action;
  logic [7:0]  drop_count;

  always #5 clk = ~clk;

  nios_dbg_cmd_queue dut (
    .clk(clk), .reset(reset), .vs_udr(vs_udr), .vs_uir(vs_uir),
    .jtag_rti(jtag_rti), .ir_in(ir_in), .sr(sr), .cmd_ready(cmd_ready),
    .ovf_clear(ovf_clear), .cmd_valid(cmd_valid), .cmd_ir(cmd_ir),
    .cmd_data(cmd_data), .jdo(jdo), .take_action(take_action),
    .take_no_action(take_no_action), .ir_update(ir_update),
    .st_ready_test_idle(st_ready_test_idle), .ovf(ovf), .drop_count(drop_count)
  );

  typedef struct {
    logic [1:0]  ir;
    logic [37:0] d;
    logic [3:0]  ea;
    logic [3:0]  ena;
  } vec_t;

  int errors = 0;
  int checks = 0;

  logic [39:0] q[$];
  logic        ovf_m;
  int          drop_m;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [37:0] rnd38();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[37:0];
  endfunction

  // {take_action, take_no_action} expected for a popped command
  function automatic logic [7:0] exp_pulse(input logic [1:0] ir, input logic [37:0] d);
    logic [3:0] oh;
    oh = 4'b0001 << ir;
    return d[34] ? {oh, 4'b0000} : {4'b0000, oh};
  endfunction

  task automatic scan(input logic [1:0] ir, input logic [37:0] d);
    ir_in  = ir;
    sr     = d;
    vs_udr = 1'b1;
    repeat (3) step();
    vs_udr = 1'b0;
    repeat (3) step();
  endtask

  task automatic m_scan(input logic [1:0] ir, input logic [37:0] d);
    if (q.size() < 4) q.push_back({ir, d});
    else begin
      ovf_m = 1'b1;
      if (drop_m < 255) drop_m++;
    end
    scan(ir, d);
    chk("scan_valid", cmd_valid, q.size() > 0);
    chk("scan_ovf", ovf, ovf_m);
    chk("scan_drops", drop_count, drop_m);
  endtask

  task automatic pop_chk(input logic [1:0] ir, input logic [37:0] d,
                         input logic [3:0] ea, input logic [3:0] ena);
    chk("head_valid", cmd_valid, 1);
    chk("head_ir", cmd_ir, ir);
    chk("head_data", cmd_data, d);
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    chk("jdo", jdo, d);
    chk("take_action", take_action, ea);
    chk("take_no_action", take_no_action, ena);
    step();
    chk("pulse_end", {take_action, take_no_action}, 0);
    chk("jdo_hold", jdo, d);
  endtask

  task automatic m_pop();
    logic [39:0] e;
    logic [7:0]  p;
    if (q.size() == 0) begin
      chk("empty_valid", cmd_valid, 0);
    end else begin
      e = q.pop_front();
      p = exp_pulse(e[39:38], e[37:0]);
      pop_chk(e[39:38], e[37:0], p[7:4], p[3:0]);
    end
  endtask

  task automatic m_clear();
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    ovf_m  = 1'b0;
    drop_m = 0;
    chk("clr_ovf", ovf, ovf_m);
    chk("clr_drops", drop_count, drop_m);
  endtask

  initial begin
    vec_t        tbl[4];
    logic [39:0] e;
    logic [37:0] nd;
    logic [7:0]  p;

    tbl[0] = '{ir: 2'd2, d: 38'h04_0000_00AA, ea: 4'b0100, ena: 4'b0000};
    tbl[1] = '{ir: 2'd2, d: 38'h00_0000_00AA, ea: 4'b0000, ena: 4'b0100};
    tbl[2] = '{ir: 2'd1, d: 38'h3F_FFFF_FFFF, ea: 4'b0010, ena: 4'b0000};
    tbl[3] = '{ir: 2'd3, d: 38'h3B_FFFF_FFFF, ea: 4'b0000, ena: 4'b1000};

    reset = 1'b1; vs_udr = 1'b0; vs_uir = 1'b0; jtag_rti = 1'b0;
    cmd_ready = 1'b0; ovf_clear = 1'b0; ir_in = '0; sr = '0;
    ovf_m = 1'b0; drop_m = 0;
    repeat (2) step();
    chk("rst_valid", cmd_valid, 0);
    chk("rst_jdo", jdo, 0);
    chk("rst_pulses", {take_action, take_no_action}, 0);
    chk("rst_ovf", {ovf, drop_count}, 0);
    chk("rst_iru_rti", {ir_update, st_ready_test_idle}, 0);
    reset = 1'b0;
    repeat (4) step();

    // push latency: first sample at edge 0, valid after edge 2
    ir_in = 2'd0; sr = 38'h04_0000_0123; vs_udr = 1'b1;
    step(); chk("lat_e0", cmd_valid, 0);
    step(); chk("lat_e1", cmd_valid, 0);
    step(); chk("lat_e2", cmd_valid, 1);
    chk("lat_data", cmd_data, 38'h04_0000_0123);
    q.push_back({2'd0, 38'h04_0000_0123});
    vs_udr = 1'b0;
    repeat (3) step();
    m_pop();

    foreach (tbl[i]) begin
      scan(tbl[i].ir, tbl[i].d);
      pop_chk(tbl[i].ir, tbl[i].d, tbl[i].ea, tbl[i].ena);
    end

    // overflow: 6 scans into depth 4, then drain, then a second fill to wrap
    for (int i = 0; i < 6; i++) m_scan(2'(i), rnd38());
    chk("ovf_count", drop_count, 2);
    chk("ovf_flag", ovf, 1);
    repeat (4) m_pop();
    chk("drained", cmd_valid, 0);
    for (int i = 0; i < 4; i++) m_scan(2'($urandom_range(0, 3)), rnd38());
    repeat (4) m_pop();

    // full queue: push coinciding with pop
    for (int i = 0; i < 4; i++) m_scan(2'($urandom_range(0, 3)), rnd38());
    e = q.pop_front();
    nd = rnd38();
    ir_in = 2'd1; sr = nd; vs_udr = 1'b1;
    step(); step();
    cmd_ready = 1'b1;
    step();
    cmd_ready = 1'b0;
    q.push_back({2'd1, nd});
    p = exp_pulse(e[39:38], e[37:0]);
    chk("pp_jdo", jdo, e[37:0]);
    chk("pp_pulse", {take_action, take_no_action}, p);
    chk("pp_drops", drop_count, 2);
    vs_udr = 1'b0;
    repeat (3) step();

    // drop with simultaneous ovf_clear: drop wins
    ir_in = 2'd3; sr = rnd38(); vs_udr = 1'b1;
    step(); step();
    ovf_clear = 1'b1;
    step();
    ovf_clear = 1'b0;
    ovf_m = 1'b1; drop_m = 1;
    chk("dc_ovf", ovf, 1);
    chk("dc_drops", drop_count, 1);
    vs_udr = 1'b0;
    repeat (3) step();
    m_clear();
    repeat (4) m_pop();

    // ir_update pulse, no queue change
    vs_uir = 1'b1;
    step(); chk("uir_e0", ir_update, 0);
    step(); chk("uir_e1", ir_update, 0);
    step(); chk("uir_e2", ir_update, 1);
    vs_uir = 1'b0;
    step(); chk("uir_e3", ir_update, 0);
    repeat (4) begin step(); chk("uir_quiet", {ir_update, cmd_valid}, 0); end

    // run-test-idle follows after two edges
    jtag_rti = 1'b1;
    step(); chk("rti_r0", st_ready_test_idle, 0);
    step(); chk("rti_r1", st_ready_test_idle, 1);
    jtag_rti = 1'b0;
    step(); chk("rti_f0", st_ready_test_idle, 1);
    step(); chk("rti_f1", st_ready_test_idle, 0);

    // random traffic
    for (int i = 0; i < 60; i++) begin
      int op;
      op = $urandom_range(0, 9);
      if (op < 5) m_scan(2'($urandom_range(0, 3)), rnd38());
      else if (op < 9) m_pop();
      else m_clear();
    end

    // saturation of drop_count
    while (q.size() < 4) m_scan(2'($urandom_range(0, 3)), rnd38());
    for (int i = 0; i < 260; i++) m_scan(2'(i), rnd38());
    chk("sat_drops", drop_count, 255);
    m_pop();
    chk("three_left", q.size() == 3 && cmd_valid, 1);

    // reset with queued commands and vs_udr high
    jtag_rti = 1'b1;
    repeat (3) step();
    vs_udr = 1'b1; reset = 1'b1;
    repeat (2) step();
    chk("r2_valid", cmd_valid, 0);
    chk("r2_jdo", jdo, 0);
    chk("r2_pulses", {take_action, take_no_action}, 0);
    chk("r2_ovf", {ovf, drop_count}, 0);
    chk("r2_iru_rti", {ir_update, st_ready_test_idle}, 0);
    reset = 1'b0; jtag_rti = 1'b0;
    q.delete(); ovf_m = 1'b0; drop_m = 0;
    repeat (8) step();
    chk("r2_nopush_hi", cmd_valid, 0);
    vs_udr = 1'b0;
    repeat (4) step();
    chk("r2_nopush_lo", cmd_valid, 0);
    m_scan(2'd2, 38'h04_1234_5678);
    m_pop();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
